// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with per-register busy scoreboard
// Optional same-cycle write-to-read bypass selected by REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int N       = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_EN = 1,
    localparam int R      = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w,
    input  logic [ADDR_W-1:0] DA,
    input  logic [N-1:0]      D,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic [N-1:0]      A,
    output logic [N-1:0]      B,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] RA,
    output logic              a_busy,
    output logic              b_busy,
    output logic [R-1:0]      busy,
    output logic [N*R-1:0]    regs
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(R - 1);

    logic [N-1:0] regs_q [R];
    logic [N-1:0] regs_d [R];
    logic [R-1:0] busy_q;
    logic [R-1:0] busy_d;
    logic         w_ok;
    logic         rsv_ok;

    // The hardwired-zero slot swallows both writes and reservations.
    assign w_ok   = w   && !((ZERO_EN != 0) && (DA == ZERO_IDX));
    assign rsv_ok = rsv && !((ZERO_EN != 0) && (RA == ZERO_IDX));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
        end else begin
            if (w_ok) begin
                regs_d[DA] = D;
                busy_d[DA] = 1'b0;
            end
            // Reserve is applied after the write so a newer producer wins on a shared address.
            if (rsv_ok) begin
                busy_d[RA] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a  = w_ok && (DA == SA);
    assign byp_b  = w_ok && (DA == SB);
    assign A      = byp_a ? D : regs_q[SA];
    assign B      = byp_b ? D : regs_q[SB];
    assign a_busy = byp_a ? 1'b0 : busy_q[SA];
    assign b_busy = byp_b ? 1'b0 : busy_q[SB];
`else
    assign A      = regs_q[SA];
    assign B      = regs_q[SB];
    assign a_busy = busy_q[SA];
    assign b_busy = busy_q[SB];
`endif

    assign busy = busy_q;

    for (genvar i = 0; i < R; i++) begin : g_regs
        assign regs[N*i +: N] = regs_q[i];
    end

endmodule
